// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W_DEF   = 5;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W_DEF   = 32;

  // Data-memory wait tracking states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Pipeline-register enables and flushes driven to the datapath.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_flush;
    logic exmem_write;
    logic memwb_write;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                         idex_write: 1'b1, idex_flush: 1'b0,
                                         exmem_write: 1'b1, memwb_write: 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Ports: clk_i clock, rst_i async active-low reset, inc_i count enable,
//        cnt_o current count.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, data-memory wait stalls with a timeout watchdog,
// and saturating stall/flush performance counters.
// Ports: clk_i/rst_i clock and async active-low reset; ifid_rs1_i/ifid_rs2_i,
//   idex_rd_i/idex_memread_i hazard sources; branch_taken_i from EX;
//   exmem_memread_i/exmem_memwrite_i/dmem_ready_i memory handshake;
//   dmem_req_o, pipeline enables/flushes (combinational), err_o sticky
//   timeout, stall_cnt_o/flush_cnt_o performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W   = REG_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic             idex_memread_i,
  input  logic             branch_taken_i,
  input  logic             exmem_memread_i,
  input  logic             exmem_memwrite_i,
  input  logic             dmem_ready_i,
  output logic             dmem_req_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_write_o,
  output logic             idex_flush_o,
  output logic             exmem_write_o,
  output logic             memwb_write_o,
  output logic             err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WCNT_W = $clog2(TIMEOUT) + 1;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic                acc;
  logic                mem_stall;
  logic                load_use;
  logic                branch_flush;
  pipe_ctrl_t          ctrl;

  // Hazard classification, highest priority first.
  assign acc          = exmem_memread_i | exmem_memwrite_i;
  assign mem_stall    = (acc & ~dmem_ready_i) | (state_q == ERR);
  assign branch_flush = ~mem_stall & branch_taken_i;
  assign load_use     = ~mem_stall & ~branch_taken_i & idex_memread_i &
                        (idex_rd_i != '0) &
                        ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state and pipeline control.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    ctrl       = CTRL_RUN;

    unique case (state_q)
      IDLE: begin
        if (acc && !dmem_ready_i) begin
          state_d    = WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      WAIT: begin
        // A dropped request or a completed access both return to IDLE.
        if (!acc || dmem_ready_i) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (mem_stall) begin
      ctrl = CTRL_FREEZE;
    end else if (branch_flush) begin
      ctrl.ifid_flush = 1'b1;
      ctrl.idex_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX.
      ctrl.pc_write   = 1'b0;
      ctrl.ifid_write = 1'b0;
      ctrl.idex_flush = 1'b1;
    end

    // Nothing moves while reset is held.
    if (!rst_i) begin
      ctrl = CTRL_FREEZE;
    end
  end

  assign dmem_req_o    = rst_i & acc & (state_q != ERR);
  assign pc_write_o    = ctrl.pc_write;
  assign ifid_write_o  = ctrl.ifid_write;
  assign ifid_flush_o  = ctrl.ifid_flush;
  assign idex_write_o  = ctrl.idex_write;
  assign idex_flush_o  = ctrl.idex_flush;
  assign exmem_write_o = ctrl.exmem_write;
  assign memwb_write_o = ctrl.memwb_write;
  assign err_o         = err_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (mem_stall | load_use),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (branch_flush),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned T    = 4;
  localparam int unsigned CW   = 8;
  localparam int          CMAX = 255;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [4:0]    ifid_rs1_i, ifid_rs2_i, idex_rd_i;
  logic          idex_memread_i, branch_taken_i;
  logic          exmem_memread_i, exmem_memwrite_i, dmem_ready_i;
  logic          dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
  logic          idex_write_o, idex_flush_o, exmem_write_o, memwb_write_o;
  logic          err_o;
  logic [CW-1:0] stall_cnt_o, flush_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: sticky error, consecutive unready-access cycles,
  // and the two counter values.
  bit m_err;
  int m_streak;
  int m_stall;
  int m_flush;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(5), .TIMEOUT(T), .CNT_W(CW)) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .ifid_rs1_i       (ifid_rs1_i),
    .ifid_rs2_i       (ifid_rs2_i),
    .idex_rd_i        (idex_rd_i),
    .idex_memread_i   (idex_memread_i),
    .branch_taken_i   (branch_taken_i),
    .exmem_memread_i  (exmem_memread_i),
    .exmem_memwrite_i (exmem_memwrite_i),
    .dmem_ready_i     (dmem_ready_i),
    .dmem_req_o       (dmem_req_o),
    .pc_write_o       (pc_write_o),
    .ifid_write_o     (ifid_write_o),
    .ifid_flush_o     (ifid_flush_o),
    .idex_write_o     (idex_write_o),
    .idex_flush_o     (idex_flush_o),
    .exmem_write_o    (exmem_write_o),
    .memwb_write_o    (memwb_write_o),
    .err_o            (err_o),
    .stall_cnt_o      (stall_cnt_o),
    .flush_cnt_o      (flush_cnt_o)
  );

  task automatic chk(input string ctx, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0h expected %0h", ctx, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check just after, advance the model.
  task automatic step(input string ctx, input bit rst, input int rs1, input int rs2,
                      input int rd, input bit idmr, input bit br, input bit mr,
                      input bit mw, input bit rdy);
    bit acc, ms, lu;
    logic [7:0] e;
    @(negedge clk);
    rst_i            = rst;
    ifid_rs1_i       = 5'(rs1);
    ifid_rs2_i       = 5'(rs2);
    idex_rd_i        = 5'(rd);
    idex_memread_i   = idmr;
    branch_taken_i   = br;
    exmem_memread_i  = mr;
    exmem_memwrite_i = mw;
    dmem_ready_i     = rdy;
    if (!rst) begin
      m_err = 1'b0; m_streak = 0; m_stall = 0; m_flush = 0;
    end
    #1;
    acc = mr || mw;
    ms  = m_err || (acc && !rdy);
    lu  = !ms && !br && idmr && (rd != 0) && (rd == rs1 || rd == rs2);
    // bit order: req, pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w
    if (!rst)      e = 8'b0000_0000;
    else if (ms)   e = {acc && !m_err, 7'b000_0000};
    else if (br)   e = {acc, 7'b111_1111};
    else if (lu)   e = {acc, 7'b000_1111};
    else           e = {acc, 7'b110_1011};
    chk(ctx, "ctrl", {24'd0, dmem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
                      idex_write_o, idex_flush_o, exmem_write_o, memwb_write_o}, {24'd0, e});
    chk(ctx, "err", {31'd0, err_o}, {31'd0, m_err});
    chk(ctx, "stall_cnt", {24'd0, stall_cnt_o}, 32'(m_stall));
    chk(ctx, "flush_cnt", {24'd0, flush_cnt_o}, 32'(m_flush));
    if (rst) begin
      if ((ms || lu) && m_stall < CMAX) m_stall++;
      if (!ms && br && m_flush < CMAX) m_flush++;
      if (!m_err) begin
        if (acc && !rdy) begin
          m_streak++;
          if (m_streak == int'(T)) m_err = 1'b1;
        end else begin
          m_streak = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    step("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_err = 1'b0; m_streak = 0; m_stall = 0; m_flush = 0;

    // Reset state.
    do_reset();
    chk("reset", "pc_write", {31'd0, pc_write_o}, 32'd0);
    chk("reset", "dmem_req", {31'd0, dmem_req_o}, 32'd0);

    // Load-use hazard on rs2.
    idle("pre_lu");
    step("lu", 1'b1, 1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("lu", "pc_write", {31'd0, pc_write_o}, 32'd0);
    chk("lu", "idex_flush", {31'd0, idex_flush_o}, 32'd1);
    idle("lu_after");
    chk("lu_after", "stall_cnt_const", {24'd0, stall_cnt_o}, 32'd1);
    chk("lu_after", "pc_write", {31'd0, pc_write_o}, 32'd1);

    // Destination x0 never creates a hazard.
    do_reset();
    step("x0", 1'b1, 0, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("x0", "pc_write", {31'd0, pc_write_o}, 32'd1);
    idle("x0_after");
    chk("x0_after", "stall_cnt_const", {24'd0, stall_cnt_o}, 32'd0);

    // Branch wins over a simultaneous load-use.
    do_reset();
    step("br_lu", 1'b1, 7, 2, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_lu", "ifid_flush", {31'd0, ifid_flush_o}, 32'd1);
    chk("br_lu", "pc_write", {31'd0, pc_write_o}, 32'd1);
    idle("br_lu_after");
    chk("br_lu_after", "flush_cnt_const", {24'd0, flush_cnt_o}, 32'd1);
    chk("br_lu_after", "stall_cnt_const", {24'd0, stall_cnt_o}, 32'd0);

    // Load with three wait cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step("wait3", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("wait3", "dmem_req", {31'd0, dmem_req_o}, 32'd1);
    end
    step("wait3_done", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wait3_done", "memwb_write", {31'd0, memwb_write_o}, 32'd1);
    idle("wait3_after");
    chk("wait3_after", "stall_cnt_const", {24'd0, stall_cnt_o}, 32'd3);
    // A zero-wait store right after must not stall (FSM back in IDLE).
    step("zero_wait", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("zero_wait", "exmem_write", {31'd0, exmem_write_o}, 32'd1);

    // Timeout: ready never rises.
    do_reset();
    for (int i = 0; i < int'(T); i++)
      step("timeout", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("err", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("err", "err_const", {31'd0, err_o}, 32'd1);
    chk("err", "dmem_req", {31'd0, dmem_req_o}, 32'd0);
    step("err_ready", 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("err_ready", "pc_write", {31'd0, pc_write_o}, 32'd0);
    // Stay frozen long enough to saturate the stall counter.
    for (int i = 0; i < 260; i++) idle("err_sat");
    chk("err_sat", "stall_cnt_sat", {24'd0, stall_cnt_o}, 32'd255);

    // Reset in the middle of a wait.
    do_reset();
    step("midwait", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("midwait", 1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("midwait_rst", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("midwait_rst", "dmem_req", {31'd0, dmem_req_o}, 32'd0);
    chk("midwait_rst", "stall_cnt_const", {24'd0, stall_cnt_o}, 32'd0);
    idle("midwait_release");
    chk("midwait_release", "pc_write", {31'd0, pc_write_o}, 32'd1);
    chk("midwait_release", "err_const", {31'd0, err_o}, 32'd0);

    // Flush counter saturation with back-to-back taken branches.
    do_reset();
    for (int i = 0; i < 260; i++)
      step("br_sat", 1'b1, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_sat", "flush_cnt_sat", {24'd0, flush_cnt_o}, 32'd255);

    // Randomized traffic with small register indices to provoke matches.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      bit r, idmr, br, mr, mw, rdy;
      int rs1, rs2, rd;
      r    = ($urandom_range(0, 39) != 0);
      rs1  = int'($urandom_range(0, 3));
      rs2  = int'($urandom_range(0, 3));
      rd   = int'($urandom_range(0, 3));
      idmr = ($urandom_range(0, 1) == 1);
      br   = ($urandom_range(0, 4) == 0);
      mr   = ($urandom_range(0, 3) == 0);
      mw   = ($urandom_range(0, 5) == 0);
      rdy  = ($urandom_range(0, 9) < 6);
      step("random", r, rs1, rs2, rd, idmr, br, mr, mw, rdy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
